uart_irq_ctrl: RTL and testbench
================================

Name: uart_irq_ctrl

Overview:
16550-style interrupt controller for the UART core. Collects receiver-line-status, receive-data-available, character-timeout and transmitter-holding-empty events from the register file, rx/tx FIFOs and rx engine. Applies IER enables and fixed priority, then drives a registered IIR code and the irq line. Owns the character-timeout counter and the THRE set/clear sequencing.

Parameters:
TICKS_PER_BIT, 16, baud_pulse ticks per serial bit time
TIMEOUT_CHARS, 4, character times of rx idle before CTI
CNT_W, 10, timeout counter width; must hold TIMEOUT_CHARS*12*TICKS_PER_BIT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
baud_pulse  in  1  one-cycle oversample tick
ier  in  4  [0] ERBFI, [1] ETBEI, [2] ELSI, [3] EDSSI
wls  in  2  word length select (5+wls data bits)
pen  in  1  parity enable
stb  in  1  extra stop bit
lsr_err  in  1  level: any of OE/PE/FE/BI set in LSR
lsr_rd  in  1  pulse: host read of LSR
rx_level_hit  in  1  level: rx FIFO count >= trigger threshold
rx_fifo_empty  in  1  level
rx_push  in  1  pulse: rx FIFO write
rx_pop  in  1  pulse: rx FIFO read (RBR read)
tx_fifo_empty  in  1  level
thr_wr  in  1  pulse: host write to THR
iir_rd  in  1  pulse: host read of IIR
iir  out  4  interrupt identification code
irq  out  1  interrupt request, active-high
cti_pend  out  1  character-timeout pending

Behaviour:
- Reset: iir=4'b0001, irq=0, cti_pend=0, THRE pending=0, timeout counter=0, tx_fifo_empty history=1.
- Char length L = 1 + (5+wls) + pen + 1 + stb bits (7..12). Timeout limit = TIMEOUT_CHARS*L*TICKS_PER_BIT, recomputed combinationally each cycle.
- Timeout counter: cleared when rx_fifo_empty=1, or on rx_push, or on rx_pop; otherwise +1 per baud_pulse, saturating at limit. When count==limit: cti_pend=1. cti_pend clears on rx_pop, rx_push, or rx_fifo_empty.
- RLS source = lsr_err & ier[2]; clears via lsr_rd upstream (level input).
- RDA source = rx_level_hit & ier[0].
- CTI source = cti_pend & ier[0].
- THRE pending: set on tx_fifo_empty 0->1 edge while ier[1]=1, or on ier[1] 0->1 while tx_fifo_empty=1. Cleared by thr_wr, by ier[1]=0, or by an iir_rd whose returned iir is 0010. Set and clear in same cycle: set wins.
- Priority (high->low): RLS 0110, RDA 0100, CTI 1100, THRE 0010, none 0001.
- iir register: updated every cycle from current sources, one-cycle latency; value returned by iir_rd is the value present in the iir_rd cycle.
- irq = ~iir[0], registered alongside iir. ier change takes effect on irq one cycle later.
- Counter never wraps: saturates at limit. Limit decreasing below the current count forces cti_pend=1 on the next baud_pulse.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); no pending event survives.

Optional Feature:
UART_MODEM_IRQ_EN: adds inputs msr_delta (level: any DCTS/DDSR/TERI/DDCD set) and msr_rd (pulse). Modem source = msr_delta & ier[3], lowest priority, code 0000. Without the macro: ports absent, ier[3] ignored, code 0000 is never produced.

Test Plan:
Reset -> iir=0001, irq=0; ier=4'b0010 with tx_fifo_empty=1 -> iir=0010, irq=1 two cycles later; iir_rd -> iir=0001 next cycle.
THRE pending, thr_wr then tx_fifo_empty 1->0->1 -> irq drops after thr_wr, reasserts 0010 one cycle after the empty edge.
ier=0001, wls=3, pen=0, stb=0 (L=10): one rx_push, then idle -> cti_pend after 640 baud_pulses, iir=1100; rx_pop -> iir=0001.
lsr_err=1 and rx_level_hit=1 with ier=0101 -> iir=0110; lsr_err drops -> iir=0100.
Same cycle: iir_rd returning 0010 plus new tx_fifo_empty rising edge -> THRE stays pending, iir remains 0010.
Macro on: ier=1000, msr_delta=1 -> iir=0000, irq=1; msr_rd with msr_delta=0 -> iir=0001.

Source files
------------

// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl: 16550-style interrupt prioritiser with char-timeout and THRE sequencing.
// Ports: clk/rst, baud_pulse, ier, wls/pen/stb, rx/tx/lsr events -> iir, irq, cti_pend.
// Option UART_MODEM_IRQ_EN adds msr_delta/msr_rd and the modem-status source (code 0000).
module uart_irq_ctrl #(
  parameter int TICKS_PER_BIT = 16,
  parameter int TIMEOUT_CHARS = 4,
  parameter int CNT_W         = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [3:0] ier,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       stb,
  input  logic       lsr_err,
  input  logic       lsr_rd,
  input  logic       rx_level_hit,
  input  logic       rx_fifo_empty,
  input  logic       rx_push,
  input  logic       rx_pop,
  input  logic       tx_fifo_empty,
  input  logic       thr_wr,
  input  logic       iir_rd,
`ifdef UART_MODEM_IRQ_EN
  input  logic       msr_delta,
  input  logic       msr_rd,
`endif
  output logic [3:0] iir,
  output logic       irq,
  output logic       cti_pend
);

  // read strobes are consumed by the register file, not here
  logic unused_in;
`ifdef UART_MODEM_IRQ_EN
  assign unused_in = lsr_rd ^ msr_rd;
`else
  assign unused_in = lsr_rd ^ ier[3];
`endif

  // start + data + parity + stop bits
  logic [3:0] char_len;
  assign char_len = 4'd7 + {2'b00, wls}
                  + {3'b000, pen} + {3'b000, stb};

  logic [CNT_W-1:0] limit;
  assign limit = CNT_W'(TIMEOUT_CHARS * TICKS_PER_BIT
                 * int'(char_len));

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = cnt + CNT_W'(1);

  logic rx_clr;
  assign rx_clr = rx_fifo_empty | rx_push | rx_pop;

  // count >= limit also covers a limit that shrank below count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      cti_pend <= 1'b0;
    end else if (rx_clr) begin
      cnt      <= '0;
      cti_pend <= 1'b0;
    end else if (baud_pulse) begin
      if (cnt >= limit) begin
        cnt      <= limit;
        cti_pend <= 1'b1;
      end else begin
        cnt <= cnt_inc;
        if (cnt_inc == limit) cti_pend <= 1'b1;
      end
    end
  end

  logic thre_pend;
  logic tx_empty_q;
  logic etbei_q;
  logic thre_set;
  logic thre_clr;

  assign thre_set = ier[1] & tx_fifo_empty
                  & (~tx_empty_q | ~etbei_q);
  assign thre_clr = thr_wr | ~ier[1]
                  | (iir_rd & (iir == 4'b0010));

  // set beats clear when both land in one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thre_pend  <= 1'b0;
      tx_empty_q <= 1'b1;
      etbei_q    <= 1'b0;
    end else begin
      tx_empty_q <= tx_fifo_empty;
      etbei_q    <= ier[1];
      if (thre_set)      thre_pend <= 1'b1;
      else if (thre_clr) thre_pend <= 1'b0;
    end
  end

  logic src_rls;
  logic src_rda;
  logic src_cti;
  logic src_thre;
  assign src_rls  = lsr_err & ier[2];
  assign src_rda  = rx_level_hit & ier[0];
  assign src_cti  = cti_pend & ier[0];
  assign src_thre = thre_pend;

  // one-hot selects so the decoder sees exclusive arms
  logic sel_rls;
  logic sel_rda;
  logic sel_cti;
  logic sel_thre;
  assign sel_rls  = src_rls;
  assign sel_rda  = src_rda & ~src_rls;
  assign sel_cti  = src_cti & ~src_rda & ~src_rls;
  assign sel_thre = src_thre & ~src_cti
                  & ~src_rda & ~src_rls;

`ifdef UART_MODEM_IRQ_EN
  logic sel_msr;
  assign sel_msr = msr_delta & ier[3] & ~src_thre
                 & ~src_cti & ~src_rda & ~src_rls;
`endif

  logic [3:0] iir_next;
  always_comb begin
    iir_next = 4'b0001;
    unique case (1'b1)
      sel_rls:  iir_next = 4'b0110;
      sel_rda:  iir_next = 4'b0100;
      sel_cti:  iir_next = 4'b1100;
      sel_thre: iir_next = 4'b0010;
`ifdef UART_MODEM_IRQ_EN
      sel_msr:  iir_next = 4'b0000;
`endif
      default:  iir_next = 4'b0001;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iir <= 4'b0001;
      irq <= 1'b0;
    end else begin
      iir <= iir_next;
      irq <= ~iir_next[0];
    end
  end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// tb_uart_irq_ctrl: directed bench for uart_irq_ctrl.
// Inputs change after negedge; outputs sampled on negedge.
module tb_uart_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse;
  logic [3:0] ier;
  logic [1:0] wls;
  logic       pen;
  logic       stb;
  logic       lsr_err;
  logic       lsr_rd;
  logic       rx_level_hit;
  logic       rx_fifo_empty;
  logic       rx_push;
  logic       rx_pop;
  logic       tx_fifo_empty;
  logic       thr_wr;
  logic       iir_rd;
`ifdef UART_MODEM_IRQ_EN
  logic       msr_delta;
  logic       msr_rd;
`endif
  logic [3:0] iir;
  logic       irq;
  logic       cti_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_irq_ctrl dut (
    .clk(clk),
    .rst(rst),
    .baud_pulse(baud_pulse),
    .ier(ier),
    .wls(wls),
    .pen(pen),
    .stb(stb),
    .lsr_err(lsr_err),
    .lsr_rd(lsr_rd),
    .rx_level_hit(rx_level_hit),
    .rx_fifo_empty(rx_fifo_empty),
    .rx_push(rx_push),
    .rx_pop(rx_pop),
    .tx_fifo_empty(tx_fifo_empty),
    .thr_wr(thr_wr),
    .iir_rd(iir_rd),
`ifdef UART_MODEM_IRQ_EN
    .msr_delta(msr_delta),
    .msr_rd(msr_rd),
`endif
    .iir(iir),
    .irq(irq),
    .cti_pend(cti_pend)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    baud_pulse = 0; ier = 4'b0000;
    wls = 2'd3; pen = 0; stb = 0;
    lsr_err = 0; lsr_rd = 0;
    rx_level_hit = 0; rx_fifo_empty = 1;
    rx_push = 0; rx_pop = 0;
    tx_fifo_empty = 1; thr_wr = 0; iir_rd = 0;
`ifdef UART_MODEM_IRQ_EN
    msr_delta = 0; msr_rd = 0;
`endif
    step(3);
    checks++;
    if (iir !== 4'b0001) begin
      errors++;
      $display("FAIL reset_iir got %b want 0001", iir);
    end
    checks++;
    if (irq !== 1'b0 || cti_pend !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b/%b want 0/0",
               irq, cti_pend);
    end
    rst = 1'b1;
    step(2);
    checks++;
    if (iir !== 4'b0001) begin
      errors++;
      $display("FAIL idle_iir got %b want 0001", iir);
    end
  endtask

  task automatic test_thre_basic;
    ier = 4'b0010;
    step(2);
    checks++;
    if (iir !== 4'b0010 || irq !== 1'b1) begin
      errors++;
      $display("FAIL thre_on got %b/%b want 0010/1",
               iir, irq);
    end
    iir_rd = 1;
    step(1);
    iir_rd = 0;
    step(1);
    checks++;
    if (iir !== 4'b0001 || irq !== 1'b0) begin
      errors++;
      $display("FAIL thre_rd got %b/%b want 0001/0",
               iir, irq);
    end
  endtask

  task automatic test_thre_write;
    ier = 4'b0000;
    step(1);
    ier = 4'b0010;
    step(2);
    checks++;
    if (iir !== 4'b0010) begin
      errors++;
      $display("FAIL thre_rearm got %b want 0010", iir);
    end
    thr_wr = 1; tx_fifo_empty = 0;
    step(1);
    thr_wr = 0;
    step(1);
    checks++;
    if (iir !== 4'b0001 || irq !== 1'b0) begin
      errors++;
      $display("FAIL thr_wr got %b/%b want 0001/0",
               iir, irq);
    end
    step(3);
    tx_fifo_empty = 1;
    step(1);
    checks++;
    if (iir !== 4'b0001) begin
      errors++;
      $display("FAIL edge_lat got %b want 0001", iir);
    end
    step(1);
    checks++;
    if (iir !== 4'b0010 || irq !== 1'b1) begin
      errors++;
      $display("FAIL edge_set got %b/%b want 0010/1",
               iir, irq);
    end
  endtask

  task automatic test_set_wins;
    tx_fifo_empty = 0;
    step(1);
    iir_rd = 1; tx_fifo_empty = 1;
    step(1);
    iir_rd = 0;
    step(2);
    checks++;
    if (iir !== 4'b0010 || irq !== 1'b1) begin
      errors++;
      $display("FAIL set_wins got %b/%b want 0010/1",
               iir, irq);
    end
    ier = 4'b0000;
    step(2);
    checks++;
    if (iir !== 4'b0001) begin
      errors++;
      $display("FAIL ier_off got %b want 0001", iir);
    end
  endtask

  task automatic test_cti;
    ier = 4'b0001; wls = 2'd3; pen = 0; stb = 0;
    rx_fifo_empty = 0; rx_push = 1;
    step(1);
    rx_push = 0; baud_pulse = 1;
    step(639);
    checks++;
    if (cti_pend !== 1'b0) begin
      errors++;
      $display("FAIL cti_639 got %b want 0", cti_pend);
    end
    step(1);
    checks++;
    if (cti_pend !== 1'b1) begin
      errors++;
      $display("FAIL cti_640 got %b want 1", cti_pend);
    end
    step(1);
    checks++;
    if (iir !== 4'b1100 || irq !== 1'b1) begin
      errors++;
      $display("FAIL cti_iir got %b/%b want 1100/1",
               iir, irq);
    end
    step(5);
    checks++;
    if (iir !== 4'b1100 || cti_pend !== 1'b1) begin
      errors++;
      $display("FAIL cti_sat got %b/%b want 1100/1",
               iir, cti_pend);
    end
    baud_pulse = 0; rx_pop = 1;
    step(1);
    rx_pop = 0;
    step(1);
    checks++;
    if (iir !== 4'b0001 || cti_pend !== 1'b0) begin
      errors++;
      $display("FAIL cti_pop got %b/%b want 0001/0",
               iir, cti_pend);
    end
  endtask

  task automatic test_limit_drop;
    wls = 2'd3; pen = 1; stb = 1;
    rx_push = 1;
    step(1);
    rx_push = 0; baud_pulse = 1;
    step(700);
    checks++;
    if (cti_pend !== 1'b0) begin
      errors++;
      $display("FAIL lim_700 got %b want 0", cti_pend);
    end
    baud_pulse = 0; wls = 2'd0; pen = 0; stb = 0;
    step(3);
    checks++;
    if (cti_pend !== 1'b0) begin
      errors++;
      $display("FAIL lim_nobaud got %b want 0", cti_pend);
    end
    baud_pulse = 1;
    step(1);
    baud_pulse = 0;
    checks++;
    if (cti_pend !== 1'b1) begin
      errors++;
      $display("FAIL lim_drop got %b want 1", cti_pend);
    end
    rx_fifo_empty = 1;
    step(2);
    checks++;
    if (cti_pend !== 1'b0 || iir !== 4'b0001) begin
      errors++;
      $display("FAIL lim_empty got %b/%b want 0/0001",
               cti_pend, iir);
    end
    wls = 2'd3;
  endtask

  task automatic test_priority;
    ier = 4'b0101; lsr_err = 1; rx_level_hit = 1;
    rx_fifo_empty = 0;
    step(1);
    checks++;
    if (iir !== 4'b0110 || irq !== 1'b1) begin
      errors++;
      $display("FAIL prio_rls got %b/%b want 0110/1",
               iir, irq);
    end
    lsr_err = 0;
    step(1);
    checks++;
    if (iir !== 4'b0100) begin
      errors++;
      $display("FAIL prio_rda got %b want 0100", iir);
    end
    ier = 4'b0100;
    step(1);
    checks++;
    if (iir !== 4'b0001 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rda_mask got %b/%b want 0001/0",
               iir, irq);
    end
    rx_level_hit = 0; rx_fifo_empty = 1; ier = 4'b0000;
    step(1);
  endtask

  task automatic test_async_reset;
    ier = 4'b0010;
    step(2);
    checks++;
    if (iir !== 4'b0010) begin
      errors++;
      $display("FAIL ar_pre got %b want 0010", iir);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (iir !== 4'b0001 || irq !== 1'b0) begin
      errors++;
      $display("FAIL ar_now got %b/%b want 0001/0",
               iir, irq);
    end
    ier = 4'b0000;
    step(1);
    rst = 1'b1;
    step(2);
    checks++;
    if (iir !== 4'b0001 || irq !== 1'b0) begin
      errors++;
      $display("FAIL ar_post got %b/%b want 0001/0",
               iir, irq);
    end
  endtask

`ifdef UART_MODEM_IRQ_EN
  task automatic test_modem;
    ier = 4'b1000; msr_delta = 1;
    step(1);
    checks++;
    if (iir !== 4'b0000 || irq !== 1'b1) begin
      errors++;
      $display("FAIL msr_on got %b/%b want 0000/1",
               iir, irq);
    end
    msr_rd = 1; msr_delta = 0;
    step(1);
    msr_rd = 0;
    checks++;
    if (iir !== 4'b0001 || irq !== 1'b0) begin
      errors++;
      $display("FAIL msr_rd got %b/%b want 0001/0",
               iir, irq);
    end
    ier = 4'b0000;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_thre_basic();
    test_thre_write();
    test_set_wins();
    test_cti();
    test_limit_drop();
    test_priority();
    test_async_reset();
`ifdef UART_MODEM_IRQ_EN
    test_modem();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
